multi_chan_stream_source: RTL

Parametrised multi-channel packet generator driving a valid/ready stream with `last` and channel-ID sideband. It produces fixed-length packets from up to `CHANNELS` logical channels in round-robin order, with a programmable inter-packet gap and a selectable data pattern. It sits at the head of mux/arbiter test chains as the stimulus source.

---
 rtl/stream_source_pkg.sv | 26 ++
 rtl/lfsr32.sv | 23 ++
 rtl/multi_chan_stream_source.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/stream_source_pkg.sv
// Shared types and constants for the multi-channel stream source.
package stream_source_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    typedef enum logic [1:0] {
        ModeCnt  = 2'd0,
        ModeLfsr = 2'd1,
        ModeId   = 2'd2,
        ModeRsvd = 2'd3
    } mode_e;

    // x^32 + x^22 + x^2 + x + 1, taps at bit positions 31, 21, 1, 0
    localparam logic [31:0] LfsrSeed = 32'h0000_0001;
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    // One Fibonacci step: shift left, feed back XOR of the tapped bits
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR that advances only when step is high.
module lfsr32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [31:0] q
);
    import stream_source_pkg::*;

    logic [31:0] q_q;

    // LFSR state register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LfsrSeed;
        end else if (step) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/multi_chan_stream_source.sv
// Round-robin multi-channel packet generator on a valid/ready stream.
module multi_chan_stream_source #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PKT_LEN  = 4,
    parameter int unsigned GAP      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic [1:0]                                    mode,
    input  logic                                          ready,
    output logic                                          valid,
    output logic [DATA_W-1:0]                             data,
    output logic                                          last,
    output logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0] id,
    output logic [15:0]                                   pkt_cnt
);
    import stream_source_pkg::*;

    localparam int unsigned IdW   = $clog2((CHANNELS > 1) ? CHANNELS : 2);
    localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [15:0]       pkt_q, pkt_d;
    logic [7:0]        gap_q, gap_d;
    logic [DATA_W-1:0] cnt_q [CHANNELS];
    logic [DATA_W-1:0] cnt_d [CHANNELS];

    logic        xfer;
    logic        last_beat;
    logic        start;
    logic        lfsr_step;
    logic [31:0] lfsr_q;
    logic        unused_lfsr;

    assign valid     = (state_q == StSend);
    assign xfer      = valid && ready;
    assign last_beat = (beat_q == BeatW'(PKT_LEN - 1));
    assign last      = valid && last_beat;
    assign id        = id_q;
    assign pkt_cnt   = pkt_q;
    assign lfsr_step = xfer && (mode_q == ModeLfsr);
    // Only the low DATA_W bits reach the output; fold the rest away
    assign unused_lfsr = ^lfsr_q;

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    // Next-state logic: FSM, beat/gap counters, packet context, channel counters
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        id_d    = id_q;
        pkt_d   = pkt_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) start = 1'b1;
            end
            StSend: begin
                if (xfer) begin
                    cnt_d[id_q] = cnt_q[id_q] + DATA_W'(1);
                    if (last_beat) begin
                        pkt_d  = pkt_q + 16'd1;
                        id_d   = (id_q == IdW'(CHANNELS - 1)) ? '0 : id_q + IdW'(1);
                        beat_d = '0;
                        if (GAP > 0) begin
                            state_d = StGap;
                            gap_d   = 8'(GAP - 1);
                        end else if (en) begin
                            start = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    if (en) start = 1'b1;
                    else    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Packet start: load context, mode is frozen for the whole packet
        if (start) begin
            state_d = StSend;
            beat_d  = '0;
            mode_d  = mode_e'(mode);
        end
    end

    // State and context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeCnt;
            beat_q  <= '0;
            id_q    <= '0;
            pkt_q   <= '0;
            gap_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            id_q    <= id_d;
            pkt_q   <= pkt_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload select; reserved mode falls back to the channel counter
    always_comb begin
        data = '0;
        if (valid) begin
            case (mode_q)
                ModeLfsr: data = lfsr_q[DATA_W-1:0];
                ModeId:   data = DATA_W'(id_q);
                default:  data = cnt_q[id_q];
            endcase
        end
    end

endmodule
